div_prenorm: RTL and testbench
==============================

# div_prenorm

Upstream operand-preparation stage for the Goldschmidt divider.
- Accepts raw unsigned 32-bit integer dividend/divisor over a valid/ready handshake.
- Normalises each operand so its leading one sits at bit 31 (the divider's .1xxx form), using a fixed 5-cycle binary-search shift.
- Issues a one-cycle `start` to the divider when it is idle, and reports the exponent correction the downstream denormaliser needs. Divide-by-zero is trapped here and never reaches the divider.

## Interface
Parameters: none (width fixed at 32, from package).

Ports:
- `clk`  in  1  clock; all state changes on posedge
- `clrn`  in  1  asynchronous active-low reset
- `in_valid`  in  1  dividend/divisor valid
- `in_ready`  out  1  block can accept; high only in IDLE
- `dividend`  in  32  unsigned integer
- `divisor`  in  32  unsigned integer
- `div_busy`  in  1  busy from divider
- `start`  out  1  one-cycle start pulse to divider
- `a`  out  32  normalised dividend, bit 31 = 1 unless `a_zero`
- `b`  out  32  normalised divisor, bit 31 = 1
- `exp_diff`  out  6  signed `sh_b - sh_a`; true quotient = (a/b)·2^exp_diff
- `a_zero`  out  1  dividend was zero
- `dbz`  out  1  one-cycle divide-by-zero pulse

## Operation
- States: IDLE, NORM, ISSUE, DBZ.
- **IDLE:** `in_ready`=1. On `in_valid`, latch the operands into working registers, clear the shift counts, clear `a_zero`, set step index k=4, and go to NORM.
- **NORM:** one step per cycle, k=4..0. For each operand independently: if the top 2^k bits are zero, shift left by 2^k and add 2^k to that operand's shift count.
  - Exactly 5 cycles, independent of data.
  - After k=0: if divisor = 0, go to DBZ. Otherwise register `a`, `b`, `exp_diff`, and `a_zero` (= dividend==0), then go to ISSUE.
- **Zero dividend:** `a`=0 and `sh_a` is forced to 0. It is still issued; the divider yields 0.
- **ISSUE:** `start` = (state==ISSUE) && !`div_busy`, which is combinational from state and `div_busy`. When `start`=1, go to IDLE. While `div_busy`=1, remain in ISSUE.
- **DBZ:** `dbz`=1 for this single cycle; `start` stays 0. Then go to IDLE. `a`, `b`, and `exp_diff` keep their previous values.
- **Output hold:** `a`, `b`, `exp_diff`, and `a_zero` stay stable from the registering edge until the next normalisation completes. The divider latches them on the `start` edge.
- **exp_diff arithmetic:** 5-bit unsigned counts, subtracted with sign extension to 6 bits. Range −31..+31, no overflow.
- **Input handshake:** `in_valid` is ignored outside IDLE, and the input is never latched twice. `in_valid` high in the same cycle ISSUE returns to IDLE is not accepted until the next cycle.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1, `start`=0, `dbz`=0, `a`=0, `b`=0, `exp_diff`=0, `a_zero`=0, k=4.
- **Latency:** acceptance at edge E0, NORM at edges E1..E5. `start` is high in the cycle after E5 if `div_busy`=0, and the divider captures at E6. Accept-to-start is therefore 6 cycles minimum.
- **Throughput:** at most one operation per 7 cycles, further limited by `div_busy`.
- **Reset mid-operation:** `clrn` low in any state forces the reset values immediately. No `start` or `dbz` is emitted for the aborted operation. `in_ready`=1 on release.
- **Busy:** `start` is never high while `div_busy`=1.

## Structure
- Package `div_pkg`:
  - state enum `prenorm_state_t` {IDLE, NORM, ISSUE, DBZ}
  - `DIV_W`=32
  - `NORM_STEPS`=5
  - `SH_W`=5
  - `EXP_W`=6
- Sub-module `prenorm_step`: combinational, one shift stage taking value, count, and k, returning the shifted value and updated count. It is instantiated twice, once for the dividend path and once for the divisor path. The FSM and registers stay in `div_prenorm`.

## Test plan
- **Basic:** dividend=1, divisor=3, `div_busy`=0 → after 6 cycles `start` is high for exactly 1 cycle, with `a`=0x80000000, `b`=0xC0000000, `exp_diff`=−1, `a_zero`=0.
- **Already normalised:** dividend=0x80000000, divisor=0xFFFFFFFF → `a`/`b` unchanged, `exp_diff`=0, `start` at cycle 6.
- **Divide by zero:** dividend=7, divisor=0 → `dbz` high for one cycle at cycle 6, `start` never asserted, `in_ready`=1 the next cycle, and `a`/`b`/`exp_diff` unchanged.
- **Zero dividend:** dividend=0, divisor=5 → `a`=0, `a_zero`=1, `b`=0xA0000000, `exp_diff`=+29, `start` issued.
- **Busy stall:** `div_busy` held high for 10 cycles after NORM completes → state stays ISSUE, `in_ready`=0, and `in_valid` pulses are ignored. `start` pulses exactly once, in the first cycle `div_busy`=0.
- **Reset mid-operation:** `clrn` asserted during NORM step k=2 → all outputs at reset values. After release there is no `start`, `in_ready`=1, and a fresh operation completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the Goldschmidt divider front end.
// Holds the operand width, normalisation step count, shift-count and
// exponent widths, and the pre-normaliser state encoding.
package div_pkg;

    localparam int DIV_W      = 32;
    localparam int NORM_STEPS = 5;
    localparam int SH_W       = 5;
    localparam int EXP_W      = 6;
    localparam int K_W        = 3;

    // First binary-search step shifts by 2^(NORM_STEPS-1) = 16.
    localparam logic [K_W-1:0] K_START = K_W'(NORM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ISSUE,
        DBZ
    } prenorm_state_t;

endpackage

// File: rtl/prenorm_step.sv
// One binary-search normalisation stage (purely combinational).
// If the top 2^k bits of value are all zero, the value is shifted left by
// 2^k and 2^k is added to the running shift count; otherwise both pass
// through unchanged.
// Ports:
//   value      in  DIV_W  operand being normalised
//   count      in  SH_W   shift accumulated so far
//   k          in  K_W    step index, 4..0
//   shifted    out DIV_W  value after this step
//   count_next out SH_W   updated shift count
module prenorm_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] value,
    input  logic [SH_W-1:0]  count,
    input  logic [K_W-1:0]   k,
    output logic [DIV_W-1:0] shifted,
    output logic [SH_W-1:0]  count_next
);

    logic [SH_W:0]    amount;     // 2^k, at most 16
    logic [DIV_W-1:0] top_mask;   // ones over the top 2^k bit positions
    logic             top_clear;

    assign amount     = (SH_W + 1)'(1) << k;
    assign top_mask   = ~({DIV_W{1'b1}} >> amount);
    assign top_clear  = (value & top_mask) == '0;
    assign shifted    = top_clear ? (value << amount) : value;
    assign count_next = top_clear ? (count + amount[SH_W-1:0]) : count;

endmodule

// File: rtl/div_prenorm.sv
// Operand pre-normaliser for the Goldschmidt divider.
// Accepts an unsigned dividend/divisor pair, left-justifies both in a fixed
// five-cycle binary search, traps divide-by-zero, and hands the normalised
// pair plus exponent correction to the divider with a one-cycle start.
// Ports:
//   clk, clrn         clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake (ready only while idle)
//   dividend, divisor raw unsigned operands
//   div_busy          divider busy; start is held off while high
//   start             one-cycle issue pulse to the divider
//   a, b              normalised dividend / divisor
//   exp_diff          signed sh_b - sh_a; quotient = (a/b) * 2^exp_diff
//   a_zero            dividend was zero (a = 0, sh_a treated as 0)
//   dbz               one-cycle divide-by-zero pulse
module div_prenorm
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIV_W-1:0]        dividend,
    input  logic [DIV_W-1:0]        divisor,
    input  logic                    div_busy,
    output logic                    start,
    output logic [DIV_W-1:0]        a,
    output logic [DIV_W-1:0]        b,
    output logic signed [EXP_W-1:0] exp_diff,
    output logic                    a_zero,
    output logic                    dbz
);

    prenorm_state_t   state, state_next;
    logic [K_W-1:0]   k;
    logic [DIV_W-1:0] work_a, work_b;
    logic [SH_W-1:0]  sh_a, sh_b;
    logic [DIV_W-1:0] step_a, step_b;
    logic [SH_W-1:0]  sh_a_next, sh_b_next;
    logic [SH_W-1:0]  sh_a_eff;
    logic             last_step;

    prenorm_step u_step_a (
        .value      (work_a),
        .count      (sh_a),
        .k          (k),
        .shifted    (step_a),
        .count_next (sh_a_next)
    );

    prenorm_step u_step_b (
        .value      (work_b),
        .count      (sh_b),
        .k          (k),
        .shifted    (step_b),
        .count_next (sh_b_next)
    );

    assign last_step = (k == '0);

    // A zero dividend runs the full search to a count of 31; force it to 0
    // so the exponent correction reflects only the divisor.
    assign sh_a_eff = (step_a == '0) ? '0 : sh_a_next;

    assign in_ready = (state == IDLE);
    assign start    = (state == ISSUE) && !div_busy;
    assign dbz      = (state == DBZ);

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (in_valid) state_next = NORM;
            NORM:  if (last_step) state_next = (step_b == '0) ? DBZ : ISSUE;
            ISSUE: if (!div_busy) state_next = IDLE;
            DBZ:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            k        <= K_START;
            work_a   <= '0;
            work_b   <= '0;
            sh_a     <= '0;
            sh_b     <= '0;
            a        <= '0;
            b        <= '0;
            exp_diff <= '0;
            a_zero   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work_a <= dividend;
                        work_b <= divisor;
                        sh_a   <= '0;
                        sh_b   <= '0;
                        a_zero <= 1'b0;
                        k      <= K_START;
                    end
                end
                NORM: begin
                    work_a <= step_a;
                    work_b <= step_b;
                    sh_a   <= sh_a_next;
                    sh_b   <= sh_b_next;
                    if (last_step) begin
                        k <= K_START;
                        // A zero divisor leaves a/b/exp_diff from the last
                        // good operation untouched.
                        if (step_b != '0) begin
                            a        <= step_a;
                            b        <= step_b;
                            a_zero   <= (step_a == '0);
                            exp_diff <= {1'b0, sh_b_next} - {1'b0, sh_a_eff};
                        end
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_prenorm.sv
module tb_div_prenorm;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        div_busy = 1'b0;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  exp_diff;
    logic        a_zero;
    logic        dbz;

    int n_cmp = 0;
    int n_mis = 0;

    div_prenorm dut (
        .clk      (clk),
        .clrn     (clrn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .div_busy (div_busy),
        .start    (start),
        .a        (a),
        .b        (b),
        .exp_diff (exp_diff),
        .a_zero   (a_zero),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Present one operand pair for exactly one accepting edge (E0); returns
    // 1 time unit after E0, i.e. inside cycle 1.
    task automatic send(input logic [31:0] dv, input logic [31:0] ds);
        @(negedge clk);
        dividend = dv;
        divisor  = ds;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Observe n cycles after E0, sampling at each falling edge.
    task automatic watch(input int n, output int first_start, output int start_cnt,
                         output int first_dbz, output int dbz_cnt, output int ready_cnt);
        first_start = 0; start_cnt = 0; first_dbz = 0; dbz_cnt = 0; ready_cnt = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (start) begin
                if (first_start == 0) first_start = c;
                start_cnt++;
            end
            if (dbz) begin
                if (first_dbz == 0) first_dbz = c;
                dbz_cnt++;
            end
            if (in_ready) ready_cnt++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (start !== 1'b0) begin n_mis++; $display("FAIL reset_start: got %b expected 0", start); end
        n_cmp++; if (dbz !== 1'b0) begin n_mis++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
        n_cmp++; if (a !== 32'h0 || b !== 32'h0) begin n_mis++; $display("FAIL reset_ab: got a=%h b=%h expected 0/0", a, b); end
        n_cmp++; if (exp_diff !== 6'h0 || a_zero !== 1'b0) begin n_mis++; $display("FAIL reset_exp: got exp=%h a_zero=%b expected 0/0", exp_diff, a_zero); end
        @(posedge clk);
        #1 clrn = 1'b1;
    endtask

    task automatic test_basic();
        int fs, sc, fd, dc, rc;
        send(32'd1, 32'd3);
        watch(10, fs, sc, fd, dc, rc);
        n_cmp++; if (fs != 6 || sc != 1) begin n_mis++; $display("FAIL basic_start: got cycle %0d count %0d expected cycle 6 count 1", fs, sc); end
        n_cmp++; if (a !== 32'h80000000) begin n_mis++; $display("FAIL basic_a: got %h expected 80000000", a); end
        n_cmp++; if (b !== 32'hC0000000) begin n_mis++; $display("FAIL basic_b: got %h expected c0000000", b); end
        n_cmp++; if (exp_diff !== 6'h3F || a_zero !== 1'b0) begin n_mis++; $display("FAIL basic_exp: got exp=%h a_zero=%b expected 3f/0", exp_diff, a_zero); end
        n_cmp++; if (rc != 4 || dc != 0) begin n_mis++; $display("FAIL basic_ready: got ready=%0d dbz=%0d expected 4/0", rc, dc); end
    endtask

    task automatic test_normalised();
        int fs, sc, fd, dc, rc;
        send(32'h80000000, 32'hFFFFFFFF);
        watch(10, fs, sc, fd, dc, rc);
        n_cmp++; if (fs != 6 || sc != 1) begin n_mis++; $display("FAIL norm_start: got cycle %0d count %0d expected cycle 6 count 1", fs, sc); end
        n_cmp++; if (a !== 32'h80000000 || b !== 32'hFFFFFFFF) begin n_mis++; $display("FAIL norm_ab: got a=%h b=%h expected 80000000/ffffffff", a, b); end
        n_cmp++; if (exp_diff !== 6'h00) begin n_mis++; $display("FAIL norm_exp: got %h expected 00", exp_diff); end
    endtask

    task automatic test_dbz();
        int fs, sc, fd, dc, rc;
        send(32'd7, 32'd0);
        watch(10, fs, sc, fd, dc, rc);
        n_cmp++; if (fd != 6 || dc != 1) begin n_mis++; $display("FAIL dbz_pulse: got cycle %0d count %0d expected cycle 6 count 1", fd, dc); end
        n_cmp++; if (sc != 0) begin n_mis++; $display("FAIL dbz_start: got %0d starts expected 0", sc); end
        n_cmp++; if (rc != 4) begin n_mis++; $display("FAIL dbz_ready: got %0d ready cycles expected 4", rc); end
        n_cmp++; if (a !== 32'h80000000 || b !== 32'hFFFFFFFF || exp_diff !== 6'h00) begin n_mis++; $display("FAIL dbz_hold: got a=%h b=%h exp=%h expected 80000000/ffffffff/00", a, b, exp_diff); end
    endtask

    task automatic test_zero_dividend();
        int fs, sc, fd, dc, rc;
        send(32'd0, 32'd5);
        watch(10, fs, sc, fd, dc, rc);
        n_cmp++; if (fs != 6 || sc != 1) begin n_mis++; $display("FAIL zero_start: got cycle %0d count %0d expected cycle 6 count 1", fs, sc); end
        n_cmp++; if (a !== 32'h0 || a_zero !== 1'b1) begin n_mis++; $display("FAIL zero_a: got a=%h a_zero=%b expected 0/1", a, a_zero); end
        n_cmp++; if (b !== 32'hA0000000) begin n_mis++; $display("FAIL zero_b: got %h expected a0000000", b); end
        n_cmp++; if (exp_diff !== 6'd29) begin n_mis++; $display("FAIL zero_exp: got %0d expected 29", exp_diff); end
    endtask

    task automatic test_busy_stall();
        int fs = 0, sc = 0, dc = 0, rc = 0, bad = 0;
        div_busy = 1'b1;
        send(32'd9, 32'd2);
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            div_busy = (c <= 15);
            in_valid = (c == 8 || c == 12);
            dividend = 32'h1234;
            divisor  = 32'h0;
            @(negedge clk);
            if (start) begin
                if (fs == 0) fs = c;
                sc++;
            end
            if (start && div_busy) bad++;
            if (dbz) dc++;
            if (in_ready && c <= 16) rc++;
        end
        in_valid = 1'b0;
        div_busy = 1'b0;
        n_cmp++; if (fs != 16 || sc != 1) begin n_mis++; $display("FAIL busy_start: got cycle %0d count %0d expected cycle 16 count 1", fs, sc); end
        n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL busy_overlap: got %0d start-while-busy cycles expected 0", bad); end
        n_cmp++; if (rc != 0 || dc != 0) begin n_mis++; $display("FAIL busy_ignore: got ready=%0d dbz=%0d expected 0/0", rc, dc); end
        n_cmp++; if (a !== 32'h90000000 || b !== 32'h80000000 || exp_diff !== 6'd2) begin n_mis++; $display("FAIL busy_values: got a=%h b=%h exp=%h expected 90000000/80000000/02", a, b, exp_diff); end
    endtask

    task automatic test_back_to_back();
        int fs = 0, ss = 0, sc = 0, rc = 0;
        @(negedge clk);
        dividend = 32'h00010000;
        divisor  = 32'h00000100;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
                if (c == 8) in_valid = 1'b0;
            end
            @(negedge clk);
            if (start) begin
                if (fs == 0) fs = c;
                else if (ss == 0) ss = c;
                sc++;
            end
            if (in_ready) rc++;
        end
        n_cmp++; if (fs != 6 || ss != 13 || sc != 2) begin n_mis++; $display("FAIL b2b_start: got %0d,%0d count %0d expected 6,13 count 2", fs, ss, sc); end
        n_cmp++; if (rc != 2) begin n_mis++; $display("FAIL b2b_ready: got %0d ready cycles expected 2", rc); end
        n_cmp++; if (a !== 32'h80000000 || b !== 32'h80000000 || exp_diff !== 6'd8) begin n_mis++; $display("FAIL b2b_values: got a=%h b=%h exp=%h expected 80000000/80000000/08", a, b, exp_diff); end
    endtask

    task automatic test_reset_mid_op();
        int fs, sc, fd, dc, rc;
        send(32'h00000F00, 32'd3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 clrn = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || start !== 1'b0 || dbz !== 1'b0) begin n_mis++; $display("FAIL rst_mid_ctrl: got ready=%b start=%b dbz=%b expected 1/0/0", in_ready, start, dbz); end
        n_cmp++; if (a !== 32'h0 || b !== 32'h0 || exp_diff !== 6'h0 || a_zero !== 1'b0) begin n_mis++; $display("FAIL rst_mid_data: got a=%h b=%h exp=%h az=%b expected all 0", a, b, exp_diff, a_zero); end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 clrn = 1'b1;
        watch(8, fs, sc, fd, dc, rc);
        n_cmp++; if (sc != 0 || dc != 0 || rc != 8) begin n_mis++; $display("FAIL rst_mid_quiet: got starts=%0d dbz=%0d ready=%0d expected 0/0/8", sc, dc, rc); end
        send(32'h00000F00, 32'd3);
        watch(10, fs, sc, fd, dc, rc);
        n_cmp++; if (fs != 6 || sc != 1) begin n_mis++; $display("FAIL rst_fresh_start: got cycle %0d count %0d expected cycle 6 count 1", fs, sc); end
        n_cmp++; if (a !== 32'hF0000000 || b !== 32'hC0000000 || exp_diff !== 6'd10) begin n_mis++; $display("FAIL rst_fresh_values: got a=%h b=%h exp=%h expected f0000000/c0000000/0a", a, b, exp_diff); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_normalised();
        test_dbz();
        test_zero_dividend();
        test_busy_stall();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
